// File: rtl/parking_slot_tracker.sv
// Eight-slot parking tracker: allocates the lowest free slot to each entering car and drives the entry gate.
// Optional macro PARKING_EXIT_CHECK_EN adds a sticky err flag for exits to slots that are already free.
module parking_slot_tracker #(
    parameter int GATE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enter_req,
    input  logic       exit_valid,
    input  logic [2:0] exit_slot,
    output logic [7:0] capacity,
    output logic [2:0] assigned_slot,
    output logic       enter_ack,
    output logic       gate_open,
    output logic       full,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE,
        ASSIGN,
        GATE,
        WAIT_CLEAR
    } state_t;

    localparam logic [7:0] GATE_LOAD = 8'(GATE_CYCLES);

    state_t     state;
    logic [7:0] gate_cnt;
    logic [2:0] pick_slot;
    logic [7:0] exit_mask;
    logic [7:0] pick_mask;
    logic [7:0] cap_next;

    function automatic logic [2:0] lowest_free(input logic [7:0] map);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (map[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // Exit sets its bit first, then the ASSIGN clear wins; a colliding exit can only target a free slot.
    always_comb begin
        pick_slot = lowest_free(capacity);
        exit_mask = exit_valid ? (8'd1 << exit_slot) : 8'd0;
        pick_mask = (state == ASSIGN) ? (8'd1 << pick_slot) : 8'd0;
        cap_next  = (capacity | exit_mask) & ~pick_mask;
    end

    assign full = (capacity == 8'h00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            capacity      <= 8'hFF;
            assigned_slot <= 3'd0;
            enter_ack     <= 1'b0;
            gate_open     <= 1'b0;
            gate_cnt      <= 8'd0;
        end else begin
            capacity  <= cap_next;
            enter_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (enter_req && (capacity != 8'h00)) state <= ASSIGN;
                end
                ASSIGN: begin
                    assigned_slot <= pick_slot;
                    enter_ack     <= 1'b1;
                    gate_cnt      <= GATE_LOAD;
                    gate_open     <= 1'b1;
                    state         <= GATE;
                end
                GATE: begin
                    if (gate_cnt <= 8'd1) begin
                        gate_open <= 1'b0;
                        gate_cnt  <= 8'd0;
                        state     <= WAIT_CLEAR;
                    end else begin
                        gate_cnt <= gate_cnt - 8'd1;
                    end
                end
                WAIT_CLEAR: begin
                    if (!enter_req) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PARKING_EXIT_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (exit_valid && capacity[exit_slot]) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_parking_slot_tracker.sv
// Scoreboard bench for parking_slot_tracker: stimulus queues expected admissions, a negedge monitor checks them.
module tb_parking_slot_tracker;

    logic       clk = 1'b0;
    logic       rst;
    logic       enter_req;
    logic       exit_valid;
    logic [2:0] exit_slot;
    logic [7:0] capacity;
    logic [2:0] assigned_slot;
    logic       enter_ack;
    logic       gate_open;
    logic       full;
    logic       err;

`ifdef PARKING_EXIT_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    logic [2:0] exp_slot_q[$];
    logic [7:0] exp_cap_q[$];
    int         gate_len   = 0;
    logic       gate_abort = 1'b0;

    parking_slot_tracker #(.GATE_CYCLES(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .enter_req     (enter_req),
        .exit_valid    (exit_valid),
        .exit_slot     (exit_slot),
        .capacity      (capacity),
        .assigned_slot (assigned_slot),
        .enter_ack     (enter_ack),
        .gate_open     (gate_open),
        .full          (full),
        .err           (err)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_admit(input logic [2:0] slot, input logic [7:0] cap);
        exp_slot_q.push_back(slot);
        exp_cap_q.push_back(cap);
    endtask

    // Monitor: every enter_ack pops one expected admission; every gate pulse must last four cycles.
    always @(negedge clk) begin
        if (enter_ack === 1'b1) begin
            checks++;
            if (exp_slot_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack: got slot %0d cap %h, expected no admission",
                         assigned_slot, capacity);
            end else begin
                logic [2:0] es;
                logic [7:0] ec;
                es = exp_slot_q.pop_front();
                ec = exp_cap_q.pop_front();
                if (assigned_slot !== es || capacity !== ec) begin
                    errors++;
                    $display("FAIL admit: got slot %0d cap %h, expected slot %0d cap %h",
                             assigned_slot, capacity, es, ec);
                end
            end
        end
        if (gate_open === 1'b1) begin
            gate_len++;
        end else if (gate_len != 0) begin
            if (gate_abort) begin
                gate_abort = 1'b0;
            end else begin
                checks++;
                if (gate_len != 4) begin
                    errors++;
                    $display("FAIL gate_len: got %0d cycles expected 4", gate_len);
                end
            end
            gate_len = 0;
        end
    end

    initial begin
        logic [7:0] cap_tab[8];
        bit         seen;
        cap_tab = '{8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
        rst = 1'b1; enter_req = 1'b0; exit_valid = 1'b0; exit_slot = 3'd0;
        cyc(2);
        rst = 1'b0;
        cyc(3);
        chk("reset_capacity", capacity, 8'hFF);
        chk("reset_full", {7'd0, full}, 8'd0);
        chk("reset_gate", {7'd0, gate_open}, 8'd0);
        chk("reset_slot", {5'd0, assigned_slot}, 8'd0);
        chk("reset_err", {7'd0, err}, 8'd0);
        chk("reset_ack", {7'd0, enter_ack}, 8'd0);

        // First car, held 10 cycles past the gate sequence: exactly one admission.
        expect_admit(3'd0, 8'hFE);
        enter_req = 1'b1;
        cyc(16);
        enter_req = 1'b0;
        cyc(2);
        chk("cap_after_first", capacity, 8'hFE);

        for (int i = 1; i < 8; i++) begin
            expect_admit(3'(i), cap_tab[i]);
            enter_req = 1'b1;
            cyc(10);
            enter_req = 1'b0;
            cyc(2);
        end
        chk("cap_full_lot", capacity, 8'h00);
        chk("full_flag", {7'd0, full}, 8'd1);
        chk("slot_held", {5'd0, assigned_slot}, 8'd7);

        // Ninth car at a full lot must not be admitted.
        enter_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            chk("ninth_gate", {7'd0, gate_open}, 8'd0);
        end

        // Exit of slot 5 while the ninth car waits; that car then gets slot 5.
        exit_valid = 1'b1; exit_slot = 3'd5;
        expect_admit(3'd5, 8'h00);
        cyc(1);
        exit_valid = 1'b0;
        chk("exit5_cap", capacity, 8'h20);
        chk("exit5_full", {7'd0, full}, 8'd0);
        cyc(12);
        enter_req = 1'b0;
        cyc(2);
        chk("refill_cap", capacity, 8'h00);

        // Exit to an already-free slot.
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        exit_valid = 1'b1; exit_slot = 3'd3;
        cyc(1);
        exit_valid = 1'b0;
        chk("dup_exit_cap", capacity, 8'hFF);
        chk("dup_exit_err", {7'd0, err}, {7'd0, EXP_ERR});
        cyc(3);
        chk("err_sticky", {7'd0, err}, {7'd0, EXP_ERR});
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("err_cleared", {7'd0, err}, 8'd0);

        // Reset on the second gate_open cycle aborts the sequence.
        expect_admit(3'd0, 8'hFE);
        enter_req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cyc(1);
            if (gate_open === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL gate_timeout: got no gate_open within 20 cycles, expected one");
        end
        cyc(1);
        rst = 1'b1;
        gate_abort = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("abort_gate", {7'd0, gate_open}, 8'd0);
        chk("abort_cap", capacity, 8'hFF);
        expect_admit(3'd0, 8'hFE);
        cyc(12);
        enter_req = 1'b0;
        cyc(2);

        // Exit of slot 0 coincident with ASSIGN: slot 1 chosen, slot 0 released.
        enter_req = 1'b1;
        expect_admit(3'd1, 8'hFD);
        cyc(1);
        exit_valid = 1'b1; exit_slot = 3'd0;
        cyc(1);
        exit_valid = 1'b0;
        chk("simul_cap", capacity, 8'hFD);
        chk("simul_err", {7'd0, err}, 8'd0);
        cyc(10);
        enter_req = 1'b0;
        cyc(2);

        for (int i = 0; i < 20 && exp_slot_q.size() != 0; i++) cyc(1);
        chk("scoreboard_drained", 8'(exp_slot_q.size()), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/parking_slot_tracker.md
PARKING_SLOT_TRACKER -- requirements
Module: parking_slot_tracker

Interface
REQ-001 Parameter: GATE_CYCLES, 4, number of cycles gate_open is held high per admitted car; legal range 1..255.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: enter_req  input  1  entry sensor level; high while a car waits at the entry gate.
REQ-005 Port: exit_valid  input  1  one-cycle pulse; a car has left slot exit_slot.
REQ-006 Port: exit_slot  input  3  index 0..7 of the slot vacated; sampled only when exit_valid=1.
REQ-007 Port: capacity  output  8  slot map, bit i=1 means slot i free; drives the new_capacity input of the downstream capacity counter.
REQ-008 Port: assigned_slot  output  3  index of the slot given to the most recently admitted car.
REQ-009 Port: enter_ack  output  1  one-cycle pulse marking a valid assigned_slot.
REQ-010 Port: gate_open  output  1  entry barrier drive.
REQ-011 Port: full  output  1  combinational, high when capacity==8'h00.
REQ-012 Port: err  output  1  sticky exit-error flag (see Configuration).

Function
REQ-013 The FSM SHALL have states IDLE, ASSIGN, GATE, WAIT_CLEAR.
REQ-014 IDLE: if enter_req=1 and capacity!=0 -> ASSIGN; otherwise stay IDLE (a car at a full lot is not admitted and no output other than full changes).
REQ-015 ASSIGN (exactly one cycle): the lowest-index 1 bit of capacity SHALL be cleared, its index loaded into assigned_slot, enter_ack=1 and gate counter loaded; next state GATE.
REQ-016 enter_ack SHALL be high during the cycle following the ASSIGN edge only, coincident with the updated assigned_slot and capacity.
REQ-017 GATE: gate_open=1 for exactly GATE_CYCLES consecutive cycles starting the cycle after ASSIGN, then -> WAIT_CLEAR.
REQ-018 WAIT_CLEAR: gate_open=0; stay until enter_req=0, then -> IDLE; a car is never admitted twice for one enter_req assertion.
REQ-019 If enter_req drops during ASSIGN or GATE, the sequence SHALL complete unchanged (slot stays allocated, full gate time).
REQ-020 exit_valid=1 SHALL set capacity[exit_slot] to 1 at the next edge, in every FSM state.
REQ-021 Simultaneous exit and ASSIGN: ASSIGN chooses from capacity as registered before the edge; both updates apply at the same edge to their own bits.
REQ-022 Exit of a slot whose bit is already 1 SHALL leave capacity unchanged.
REQ-023 assigned_slot SHALL hold its value between admissions.
REQ-024 full SHALL reflect the registered capacity only (no look-ahead).

Reset
REQ-025 rst=1 at a rising edge SHALL force: state IDLE, capacity=8'hFF, assigned_slot=0, enter_ack=0, gate_open=0, gate counter=0, err=0.
REQ-026 Reset mid-sequence (ASSIGN/GATE/WAIT_CLEAR) SHALL abort it; gate_open low the cycle after the reset edge; the allocated slot is released by the capacity reset.
REQ-027 rst SHALL take priority over exit_valid and enter_req in the same cycle.

Configuration
REQ-028 Macro PARKING_EXIT_CHECK_EN defined: an exit to an already-free slot (REQ-022) SHALL set err=1 at the next edge, held until rst.
REQ-029 Macro PARKING_EXIT_CHECK_EN undefined: err SHALL be constant 0 and no checking logic built; capacity behaviour identical.

Verification
REQ-030 Reset then idle 3 cycles -> capacity=8'hFF, full=0, gate_open=0, assigned_slot=0, err=0.
REQ-031 enter_req high from IDLE, GATE_CYCLES=4 -> enter_ack one cycle with assigned_slot=0, capacity=8'hFE, gate_open high exactly 4 cycles; holding enter_req 10 more cycles admits no second car.
REQ-032 Eight admissions -> assigned_slot 0..7 in order, capacity=8'h00, full=1; ninth enter_req -> no enter_ack, gate_open stays 0.
REQ-033 From capacity=8'h00, exit_valid slot 5 in the ASSIGN-eligible cycle with enter_req high -> capacity=8'h20, then next admission gets slot 5, capacity=8'h00.
REQ-034 With PARKING_EXIT_CHECK_EN: exit_valid slot 3 while capacity=8'hFF -> capacity stays 8'hFF, err=1 until rst; without macro err stays 0.
REQ-035 rst asserted on 2nd gate_open cycle -> next cycle gate_open=0, capacity=8'hFF, state IDLE; enter_req still high -> new admission of slot 0.
